// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the systolic array accumulator drain path.
package systolic_pkg;

    localparam int DEF_MATRIX_SIZE = 8;
    localparam int DEF_ACC_WIDTH   = 32;
    localparam int DEF_OUT_WIDTH   = 8;

    function automatic int elem_count(input int matrix_size);
        return matrix_size * matrix_size;
    endfunction

    localparam int DEF_NUM_ELEM = elem_count(DEF_MATRIX_SIZE);

    typedef logic [1:0] reader_state_t;

    localparam reader_state_t ST_IDLE  = 2'd0;
    localparam reader_state_t ST_READ  = 2'd1;
    localparam reader_state_t ST_FLUSH = 2'd2;

endpackage

// File: rtl/systolic_acc_reader_if.sv
// Valid/ready result stream leaving the accumulator drain engine.
interface systolic_acc_reader_if
    import systolic_pkg::*;
#(
    parameter int OUT_WIDTH      = DEF_OUT_WIDTH,
    parameter int ACC_ADDR_WIDTH = $clog2(DEF_NUM_ELEM)
);
    logic [OUT_WIDTH-1:0]      out_data;
    logic [ACC_ADDR_WIDTH-1:0] out_index;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output out_data, out_index, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_index, out_last, out_valid,
        output out_ready
    );
endinterface

// File: rtl/requant_sat.sv
// Combinational requantizer: arithmetic right shift with round-half-up, then saturate.
module requant_sat
    import systolic_pkg::*;
#(
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int SHIFT_WIDTH = $clog2(ACC_WIDTH) + 1
) (
    input  logic [ACC_WIDTH-1:0]   acc_in,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [OUT_WIDTH-1:0]   q
);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [ACC_WIDTH:0] ONE     = {{ACC_WIDTH{1'b0}}, 1'b1};

    // One guard bit keeps the rounding add from overflowing for shifts below ACC_WIDTH.
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] half;
    logic signed [ACC_WIDTH:0] rnd;
    logic signed [ACC_WIDTH:0] shr;

    always_comb begin
        ext  = $signed({acc_in[ACC_WIDTH-1], acc_in});
        half = '0;
        if (shift != '0) begin
            half = ONE << (shift - 1'b1);
        end
        rnd = ext + half;
        shr = rnd >>> shift;
        if (shr > SAT_MAX) begin
            q = SAT_MAX[OUT_WIDTH-1:0];
        end else if (shr < SAT_MIN) begin
            q = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            q = shr[OUT_WIDTH-1:0];
        end
    end
endmodule

// File: rtl/systolic_acc_reader.sv
// Drains the systolic array accumulators in row-major order and streams requantized
// results out through a two-stage valid/ready pipeline.
module systolic_acc_reader
    import systolic_pkg::*;
#(
    parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
    parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE * MATRIX_SIZE),
    parameter int OUT_WIDTH      = DEF_OUT_WIDTH,
    parameter int SHIFT_WIDTH    = $clog2(ACC_WIDTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SHIFT_WIDTH-1:0]    shift_amt,
    output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
    input  logic [ACC_WIDTH-1:0]      acc_out,
    systolic_acc_reader_if.master     out_if,
    output logic                      busy,
    output logic                      done
);
    // state    | meaning
    // ST_IDLE  | waiting for start; addr_acc parked at 0
    // ST_READ  | issuing one accumulator index per free S1 slot
    // ST_FLUSH | all indices issued; waiting for the last element to handshake

    localparam int NUM_ELEM = elem_count(MATRIX_SIZE);
    localparam logic [ACC_ADDR_WIDTH-1:0] LAST_IDX  = ACC_ADDR_WIDTH'(NUM_ELEM - 1);
    localparam logic [SHIFT_WIDTH-1:0]    MAX_SHIFT = SHIFT_WIDTH'(ACC_WIDTH - 1);

    reader_state_t             state;
    logic [ACC_ADDR_WIDTH-1:0] rd_ptr;
    logic [SHIFT_WIDTH-1:0]    shift_q;

    logic                      s1_valid;
    logic [ACC_WIDTH-1:0]      s1_acc;
    logic [ACC_ADDR_WIDTH-1:0] s1_index;
    logic                      s1_last;

    logic                      s2_valid;
    logic [OUT_WIDTH-1:0]      s2_data;
    logic [ACC_ADDR_WIDTH-1:0] s2_index;
    logic                      s2_last;

    logic                      s2_load;
    logic                      s1_load;
    logic                      issue;
    logic [OUT_WIDTH-1:0]      req_q;

    assign addr_acc         = rd_ptr;
    assign busy             = (state != ST_IDLE);
    assign out_if.out_valid = s2_valid;
    assign out_if.out_data  = s2_data;
    assign out_if.out_index = s2_index;
    assign out_if.out_last  = s2_last;

    always_comb begin
        s2_load = !s2_valid || out_if.out_ready;
        s1_load = !s1_valid || s2_load;
        issue   = (state == ST_READ) && s1_load;
    end

    // A start landing in the done cycle is dropped so one controller pulse cannot chain drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            rd_ptr  <= '0;
            shift_q <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !done) begin
                        shift_q <= (shift_amt > MAX_SHIFT) ? MAX_SHIFT : shift_amt;
                        rd_ptr  <= '0;
                        state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        if (rd_ptr == LAST_IDX) begin
                            rd_ptr <= '0;
                            state  <= ST_FLUSH;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (s2_valid && out_if.out_ready && s2_last) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_acc   <= '0;
            s1_index <= '0;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_index <= '0;
            s2_last  <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= issue;
                if (issue) begin
                    s1_acc   <= acc_out;
                    s1_index <= rd_ptr;
                    s1_last  <= (rd_ptr == LAST_IDX);
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data  <= req_q;
                    s2_index <= s1_index;
                    s2_last  <= s1_last;
                end
            end
        end
    end

    requant_sat #(
        .ACC_WIDTH   (ACC_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_requant (
        .acc_in (s1_acc),
        .shift  (shift_q),
        .q      (req_q)
    );
endmodule

// File: tb/tb_systolic_acc_reader.sv
// Scoreboard bench for systolic_acc_reader: directed drains with hand-computed results.
module tb_systolic_acc_reader;
    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  shift_amt = 6'd0;
    logic [5:0]  addr_acc;
    logic [31:0] acc_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int acc_mode = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    int first_valid = -1;

    logic [14:0] exp_q[$];
    bit          rst_flag = 1'b1;
    bit          prev_stall = 1'b0;
    logic [14:0] prev_word = '0;
    logic [5:0]  prev_addr = '0;

    systolic_acc_reader_if #(.OUT_WIDTH(8), .ACC_ADDR_WIDTH(6)) bus ();

    systolic_acc_reader #(
        .MATRIX_SIZE    (8),
        .ACC_WIDTH      (32),
        .ACC_ADDR_WIDTH (6),
        .OUT_WIDTH      (8),
        .SHIFT_WIDTH    (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .shift_amt (shift_amt),
        .addr_acc  (addr_acc),
        .acc_out   (acc_out),
        .out_if    (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator contents as a function of the address the DUT presents.
    always_comb begin
        acc_out = 32'd0;
        case (acc_mode)
            0: acc_out = {26'd0, addr_acc};
            1: acc_out = addr_acc[0] ? 32'hFFFF_FC18 : 32'd1000;
            2: begin
                case (addr_acc[1:0])
                    2'd0: acc_out = 32'd6;
                    2'd1: acc_out = 32'd5;
                    2'd2: acc_out = 32'hFFFF_FFFA;
                    default: acc_out = 32'hFFFF_FFF9;
                endcase
            end
            3: acc_out = 32'h7FFF_FFFF;
            default: acc_out = 32'd0;
        endcase
    end

    // Mode 0 with shift 0, mode 1 with shift 0, mode 2 with shift 2, mode 3 with shift 40.
    function automatic logic [7:0] exp_val(input int m, input int k);
        logic [7:0] v;
        v = 8'd0;
        case (m)
            0: v = k[7:0];
            1: v = (k % 2 == 0) ? 8'h7F : 8'h80;
            2: begin
                case (k % 4)
                    0: v = 8'd2;
                    1: v = 8'd1;
                    2: v = 8'hFF;
                    default: v = 8'hFE;
                endcase
            end
            3: v = 8'd1;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: bus.out_ready = ~bus.out_ready;
                2: bus.out_ready = ($urandom_range(0, 99) < 30);
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [14:0] word;
        logic [14:0] expw;
        word = {bus.out_data, bus.out_index, bus.out_last};
        if (rst) begin
            rst_flag   = 1'b1;
            prev_stall = 1'b0;
        end else begin
            if (bus.out_valid && first_valid < 0) first_valid = cyc - t0;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=none", word);
                end else begin
                    expw = exp_q.pop_front();
                    if (word !== expw) begin
                        errors++;
                        $display("FAIL element actual data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                                 word[14:7], word[6:1], word[0], expw[14:7], expw[6:1], expw[0]);
                    end
                end
            end
            if (prev_stall) begin
                checks++;
                if (!(bus.out_valid && word === prev_word)) begin
                    errors++;
                    $display("FAIL stall_hold actual=%h valid=%b required=%h valid=1", word, bus.out_valid, prev_word);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = word;
            if (!rst_flag && addr_acc != prev_addr) begin
                checks++;
                if (addr_acc !== prev_addr + 6'd1) begin
                    errors++;
                    $display("FAIL addr_step actual=%0d required=%0d", addr_acc, prev_addr + 6'd1);
                end
            end
            rst_flag  = 1'b0;
            prev_addr = addr_acc;
            if (done) begin
                done_cnt++;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL done_busy actual=%b required=0", busy);
                end
            end
        end
    end

    task automatic drain(input int amode, input int rmode, input logic [5:0] sh,
                         input int extra_start, input bit start_at_done, input bit check_lat);
        bit got;
        acc_mode   = amode;
        ready_mode = rmode;
        for (int k = 0; k < N; k++) exp_q.push_back({exp_val(amode, k), 6'(k), (k == N - 1)});
        done_cnt    = 0;
        first_valid = -1;
        got         = 1'b0;
        @(posedge clk);
        #1;
        shift_amt = sh;
        start     = 1'b1;
        t0        = cyc;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                got = 1'b1;
                break;
            end
            if (extra_start > 0 && cyc - t0 == extra_start) begin
                start     = 1'b1;
                shift_amt = 6'd5;
            end
        end
        chk("done_seen", got, 1);
        if (check_lat) begin
            chk("done_cycle", cyc - t0, 67);
            chk("first_valid_cycle", first_valid, 3);
        end
        if (start_at_done) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("idle_after_done", busy, 0);
        chk("done_count", done_cnt, 1);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic reset_mid();
        bit found;
        acc_mode   = 0;
        ready_mode = 0;
        for (int k = 0; k < N; k++) exp_q.push_back({exp_val(0, k), 6'(k), (k == N - 1)});
        done_cnt    = 0;
        first_valid = -1;
        @(posedge clk);
        #1;
        shift_amt = 6'd0;
        start     = 1'b1;
        t0        = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_index == 6'd10) begin
                found = 1'b1;
                break;
            end
        end
        chk("elem10_seen", found, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", addr_acc, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt, 0);
        chk("rst_stays_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_addr_acc", addr_acc, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_out_index", bus.out_index, 0);
        chk("reset_out_last", bus.out_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        drain(0, 0, 6'd0, 0, 1'b0, 1'b1);
        drain(1, 0, 6'd0, 0, 1'b0, 1'b0);
        drain(2, 0, 6'd2, 0, 1'b0, 1'b1);
        drain(3, 0, 6'd40, 0, 1'b0, 1'b0);
        drain(0, 1, 6'd0, 20, 1'b0, 1'b0);
        drain(2, 2, 6'd2, 0, 1'b1, 1'b0);
        reset_mid();
        drain(2, 0, 6'd2, 0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/systolic_acc_reader.md
Name: systolic_acc_reader

Overview:
Drain engine on the accumulator read port of the buffered systolic array, after a matrix product has accumulated.
- Sweeps the array's accumulator address (row-major, 0..MATRIX_SIZE²-1) and samples the combinational accumulator output.
- Requantizes each signed ACC_WIDTH result to OUT_WIDTH (arithmetic right shift, round-half-up, saturate).
- Streams the results out on a valid/ready interface with full backpressure, one element per cycle peak.
- Sits between the systolic array's accumulator readout and the result writeback/DMA logic.

Parameters:
MATRIX_SIZE, 8, array dimension; element count N = MATRIX_SIZE*MATRIX_SIZE
ACC_WIDTH, 32, signed accumulator width
ACC_ADDR_WIDTH, $clog2(MATRIX_SIZE*MATRIX_SIZE), accumulator index width
OUT_WIDTH, 8, signed output element width
SHIFT_WIDTH, $clog2(ACC_WIDTH)+1, width of requant shift amount

Ports:
clk  input  1  clock; single clock domain
rst  input  1  synchronous, active-high reset
start  input  1  pulse; begin a drain of all N elements
shift_amt  input  SHIFT_WIDTH  right-shift amount, latched on accepted start
addr_acc  output  ACC_ADDR_WIDTH  accumulator index to the array (registered)
acc_out  input  ACC_WIDTH  accumulator value at addr_acc, combinational same cycle
out_data  output  OUT_WIDTH  requantized signed element
out_index  output  ACC_ADDR_WIDTH  accumulator index of out_data
out_last  output  1  high with element N-1
out_valid  output  1  output element valid
out_ready  input  1  downstream accepts
busy  output  1  drain in progress; controller must not pulse acc_rst/acc_en
done  output  1  one-cycle pulse after final handshake

Behaviour:
- Reset (sync, rst high at edge) values: addr_acc=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, state IDLE. Reset mid-drain aborts immediately; no partial output after reset.
- FSM states:
  - IDLE: start=1 latches shift_amt (clamped to ACC_WIDTH-1 if larger), clears rd_ptr → READ.
  - READ: issue loop below; after issuing index N-1 → FLUSH.
  - FLUSH: wait until the pipeline is empty and out_last has handshaked → IDLE with done=1 for one cycle.
- busy=1 in READ and FLUSH; busy is 0 in the cycle done is high.
- start is ignored when not in IDLE.
- Pipeline: addr_acc=rd_ptr (register) → S1 captures {acc_out, index, last} → S2 is the output register (out_*). Standard valid/ready stage chaining:
  - A stage loads when it is empty or its contents move downstream this cycle.
  - Issue (capture into S1 and rd_ptr++) only in READ when S1 can load.
- out_data, out_index and out_last are held stable while out_valid=1 and out_ready=0; no drop or duplication.
- Latency with out_ready=1: start sampled in cycle 0; addr_acc=0 in cycle 1; element k is valid in cycle 3+k; last element (N=64) in cycle 66; done in cycle 67; throughput 1 element/cycle.
- Requant, performed in S1→S2:
  - Sign-extend to ACC_WIDTH+1 bits.
  - If s>0, add 1<<(s-1), then arithmetic shift right by s; if s=0, pass through.
  - Saturate to [-(2^(OUT_WIDTH-1)), 2^(OUT_WIDTH-1)-1].
- addr_acc wraps to 0 after issuing N-1 and stays 0 in IDLE.

Decomposition:
- Shared package systolic_pkg holds the reader state enum (IDLE/READ/FLUSH) and a MATRIX_SIZE-derived element-count constant. The shared ACC_WIDTH/OUT_WIDTH defaults also go there.
- One sub-module, requant_sat: purely combinational shift/round/saturate, parameterized by ACC_WIDTH, OUT_WIDTH and SHIFT_WIDTH. Reused by other writeback paths.

Test Plan:
- Basic drain: bench model acc_out=addr_acc, shift_amt=0, out_ready=1 → out_data 0..63 in order with out_index=out_data, out_last only at 63, first valid cycle 3, done single pulse in cycle 67.
- Saturation: acc_out=1000 and -1000 at alternating indices, shift 0 → out_data 127 (0x7F) and -128 (0x80).
- Rounding: shift 2 with acc 6→2, 5→1, -6→-1, -7→-2. Shift 40 (clamped to 31) with acc 0x7FFF_FFFF → 1, no internal overflow.
- Backpressure: out_ready toggling 1,0,1,0 and also random 30% duty → 64 unique in-order elements. Outputs held stable while stalled. addr_acc never skips an index.
- Start during busy: second start at cycle 20 is ignored and produces exactly 64 outputs and one done. A start pulsed in the done cycle is also ignored.
- Reset mid-drain: rst at element 10 → next cycle out_valid=0, busy=0, addr_acc=0, with no done. A new start then restarts at index 0 with the newly latched shift_amt.
